// File: rtl/bcp_pkg.sv
// Shared types and defaults for the implication queue.
// The entry type is sized for the default index width.
package bcp_pkg;

    localparam int unsigned IDX_W_DEF = 3;
    localparam int unsigned DEPTH_DEF = 8;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    typedef struct packed {
        logic [IDX_W_DEF-1:0] idx;
        logic                 val;
    } entry_t;

endpackage

// File: rtl/impl_fifo_mem.sv
// Entry storage for implication_fifo: synchronous write, asynchronous (show-ahead) read.
// Contents are not reset; the pointers in the parent decide what is valid.
module impl_fifo_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/implication_fifo.sv
// Queue of implied variable assignments with conflict detection against an assignment table.
// Optional macro IMPL_FIFO_DUP_FILTER_EN: same-polarity repeat pushes are consumed without being stored.
module implication_fifo
    import bcp_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push_valid,
    input  logic [IDX_W-1:0]         push_idx,
    input  logic                     push_val,
    output logic                     push_ready,
    output logic                     pop_valid,
    output logic [IDX_W-1:0]         pop_idx,
    output logic                     pop_val,
    input  logic                     pop_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     conflict,
    output logic [IDX_W-1:0]         conflict_idx,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned NV = 1 << IDX_W;
    localparam int unsigned EW = IDX_W + 1;

    state_e            r_state;
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [NV-1:0]     r_assigned;
    logic [NV-1:0]     r_value;
    logic              r_conflict;
    logic [IDX_W-1:0]  r_conflict_idx;
    logic              r_overflow;

    logic              w_push_fire;
    logic              w_pop_fire;
    logic              w_seen;
    logic              w_conflict_hit;
    logic              w_dup_hit;
    logic              w_write;
    logic              w_overflow_hit;
    logic [EW-1:0]     w_rdata;

    assign push_ready   = (r_state == ST_RUN) && (r_count < CW'(DEPTH));
    assign pop_valid    = (r_count != '0);
    assign count        = r_count;
    assign conflict     = r_conflict;
    assign conflict_idx = r_conflict_idx;
    assign overflow     = r_overflow;

    assign w_push_fire    = push_valid && push_ready;
    assign w_pop_fire     = pop_valid && pop_ready;
    assign w_seen         = r_assigned[push_idx];
    assign w_conflict_hit = w_push_fire && w_seen && (r_value[push_idx] != push_val);
`ifdef IMPL_FIFO_DUP_FILTER_EN
    assign w_dup_hit      = w_push_fire && w_seen && (r_value[push_idx] == push_val);
`else
    assign w_dup_hit      = 1'b0;
`endif
    assign w_write        = w_push_fire && !w_conflict_hit && !w_dup_hit;
    assign w_overflow_hit = push_valid && (r_state == ST_RUN) && (r_count == CW'(DEPTH));

    // Clear and reset both win over any push in flight, so the store is gated too.
    impl_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (EW),
        .AW    (AW)
    ) u_mem (
        .clock   (clock),
        .i_we    (w_write && reset_n && !clear),
        .i_waddr (r_wptr),
        .i_wdata ({push_idx, push_val}),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign pop_idx = w_rdata[EW-1:1];
    assign pop_val = w_rdata[0];

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            r_state        <= ST_RUN;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_assigned     <= '0;
            r_value        <= '0;
            r_conflict     <= 1'b0;
            r_conflict_idx <= '0;
            r_overflow     <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN:  if (w_conflict_hit) r_state <= ST_HALT;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_RUN;
            endcase

            if (w_write) begin
                r_wptr               <= r_wptr + AW'(1);
                r_assigned[push_idx] <= 1'b1;
                r_value[push_idx]    <= push_val;
            end
            if (w_pop_fire) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_write) - CW'(w_pop_fire);

            // Only the first conflict is recorded; later ones cannot occur once halted.
            if (w_conflict_hit && !r_conflict) begin
                r_conflict     <= 1'b1;
                r_conflict_idx <= push_idx;
            end
            if (w_overflow_hit) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_implication_fifo.sv
// Directed plus randomized bench for implication_fifo against a queue/table reference model.
module tb_implication_fifo;
    import bcp_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       clear = 1'b0;
    logic       push_valid = 1'b0;
    logic [2:0] push_idx = '0;
    logic       push_val = 1'b0;
    logic       push_ready;
    logic       pop_valid;
    logic [2:0] pop_idx;
    logic       pop_val;
    logic       pop_ready = 1'b0;
    logic [3:0] count;
    logic       conflict;
    logic [2:0] conflict_idx;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    entry_t     m_q[$];
    logic [7:0] m_asg;
    logic [7:0] m_val;
    logic       m_halt;
    logic       m_conf;
    logic [2:0] m_conf_idx;
    logic       m_ovf;
    logic       m_known = 1'b0;

    implication_fifo dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (clear),
        .push_valid   (push_valid),
        .push_idx     (push_idx),
        .push_val     (push_val),
        .push_ready   (push_ready),
        .pop_valid    (pop_valid),
        .pop_idx      (pop_idx),
        .pop_val      (pop_val),
        .pop_ready    (pop_ready),
        .count        (count),
        .conflict     (conflict),
        .conflict_idx (conflict_idx),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_flush();
        m_q.delete();
        m_asg = '0; m_val = '0;
        m_halt = 1'b0; m_conf = 1'b0; m_conf_idx = '0; m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic pv, input logic [2:0] pi, input logic pval,
                              input logic pr, input logic clr, input logic rst);
        logic   rdy;
        logic   do_pop;
        entry_t e;
        if (rst || clr) begin
            model_flush();
            m_known = 1'b1;
            return;
        end
        rdy    = !m_halt && (m_q.size() < 8);
        do_pop = (m_q.size() != 0) && pr;
        if (pv && !m_halt && m_q.size() == 8) m_ovf = 1'b1;
        if (do_pop) void'(m_q.pop_front());
        if (pv && rdy) begin
            if (m_asg[pi] && m_val[pi] != pval) begin
                if (!m_conf) m_conf_idx = pi;
                m_conf = 1'b1;
                m_halt = 1'b1;
            end else begin
`ifdef IMPL_FIFO_DUP_FILTER_EN
                if (!m_asg[pi]) begin
                    e.idx = pi; e.val = pval; m_q.push_back(e);
                end
`else
                e.idx = pi; e.val = pval; m_q.push_back(e);
`endif
                m_asg[pi] = 1'b1;
                m_val[pi] = pval;
            end
        end
    endtask

    task automatic check_outputs();
        chk("push_ready", 32'(push_ready), 32'(!m_halt && m_q.size() < 8));
        chk("pop_valid", 32'(pop_valid), 32'(m_q.size() != 0));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("conflict", 32'(conflict), 32'(m_conf));
        chk("conflict_idx", 32'(conflict_idx), 32'(m_conf_idx));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (m_q.size() != 0) begin
            chk("pop_idx", 32'(pop_idx), 32'(m_q[0].idx));
            chk("pop_val", 32'(pop_val), 32'(m_q[0].val));
        end
    endtask

    // One clock: drive inputs, check pre-edge outputs, advance model, cross the edge.
    task automatic cyc(input logic pv, input logic [2:0] pi, input logic pval,
                       input logic pr, input logic clr, input logic rst);
        push_valid = pv; push_idx = pi; push_val = pval;
        pop_ready = pr; clear = clr; reset_n = !rst;
        #1;
        if (m_known) check_outputs();
        model_step(pv, pi, pval, pr, clr, rst);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0] ri;
        int unsigned r;
        @(negedge clock);

        // Reset and reset-state check
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_push_ready", 32'(push_ready), 32'd1);

        // Basic ordering: (5,1), (2,0), then drain
        cyc(1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("order_count2", 32'(count), 32'd2);
        chk("order_head0", 32'({pop_idx, pop_val}), 32'({3'd5, 1'b1}));
        cyc(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("order_head1", 32'({pop_idx, pop_val}), 32'({3'd2, 1'b0}));
        chk("order_count1", 32'(count), 32'd1);
        cyc(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("order_count0", 32'(count), 32'd0);

        // Fill to full, then overflow
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) cyc(1'b1, 3'(k), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd8);
        chk("full_ready", 32'(push_ready), 32'd0);
        cyc(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);

        // Conflict, drain in HALT, then clear
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("conf_flag", 32'(conflict), 32'd1);
        chk("conf_idx", 32'(conflict_idx), 32'd3);
        chk("conf_count", 32'(count), 32'd1);
        chk("conf_ready", 32'(push_ready), 32'd0);
        chk("conf_head", 32'({pop_idx, pop_val}), 32'({3'd3, 1'b1}));
        cyc(1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("halt_drained", 32'(count), 32'd0);
        cyc(1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("clear_conf", 32'(conflict), 32'd0);
        chk("clear_ready", 32'(push_ready), 32'd1);
        chk("clear_beats_push", 32'(count), 32'd0);

        // Duplicate push, and push into empty with pop_ready
        cyc(1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef IMPL_FIFO_DUP_FILTER_EN
        chk("dup_count", 32'(count), 32'd1);
`else
        chk("dup_count", 32'(count), 32'd2);
`endif

        // Steady push+pop with wraparound at count=3
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 3'(k), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 3; k < 13; k++) cyc(1'b1, 3'(k), 1'b1, 1'b1, 1'b0, 1'b0);
`ifndef IMPL_FIFO_DUP_FILTER_EN
        chk("wrap_count", 32'(count), 32'd3);
`endif

        // Reset while holding 5 entries and a conflict
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b1, 3'(k), 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_conf", 32'(conflict), 32'd1);
        cyc(1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("post_rst_valid", 32'(pop_valid), 32'd0);
        chk("post_rst_ready", 32'(push_ready), 32'd1);
        chk("post_rst_conf", 32'(conflict), 32'd0);
        cyc(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_push", 32'(count), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            r  = $urandom_range(0, 199);
            ri = 3'($urandom_range(0, 7));
            cyc(($urandom_range(0, 3) != 0), ri,
                (($urandom_range(0, 15) == 0) ? ~ri[0] : ri[0]) ^ 1'((i / 100) % 2),
                (((i / 50) % 3) == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1),
                (r >= 1 && r <= 4), (r == 0));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/implication_fifo.md
IMPLICATION_FIFO -- requirements
Module: implication_fifo

Interface
REQ-001 Parameter DEPTH, default 8, queue depth in entries (power of two, >= 2).
REQ-002 Parameter IDX_W, default 3, variable-index width; matches priority-encoder output width.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 clear  input  1  synchronous flush of queue, assignment table and sticky flags.
REQ-006 push_valid  input  1  encoder result present (driven from encoder finish strobe).
REQ-007 push_idx  input  IDX_W  implied variable index.
REQ-008 push_val  input  1  implied polarity (1 = true).
REQ-009 push_ready  output  1  push will be accepted this cycle.
REQ-010 pop_valid  output  1  head entry available.
REQ-011 pop_idx  output  IDX_W  head entry variable index.
REQ-012 pop_val  output  1  head entry polarity.
REQ-013 pop_ready  input  1  consumer takes head entry.
REQ-014 count  output  log2(DEPTH)+1  entries held.
REQ-015 conflict  output  1  sticky: same variable implied with both polarities.
REQ-016 conflict_idx  output  IDX_W  variable that caused the first conflict.
REQ-017 overflow  output  1  sticky: push_valid seen while full in RUN.

Function
REQ-018 Two states, RUN and HALT; reset and clear enter RUN.
REQ-019 RUN -> HALT on a cycle where a push meets a conflict (REQ-023); HALT exits only via clear or reset.
REQ-020 push_ready = (state == RUN) and (count < DEPTH), derived from registered state only.
REQ-021 Push fires on push_valid and push_ready; its entry is visible at the head no earlier than the next cycle.
REQ-022 Assignment table: assigned[2**IDX_W] and value[2**IDX_W]; a firing push sets assigned[push_idx] and value[push_idx]=push_val; bits clear only by clear or reset.
REQ-023 Conflict: firing push with assigned[push_idx]=1 and value[push_idx]!=push_val; entry is not written, conflict set, conflict_idx=push_idx, state -> HALT.
REQ-024 Pop fires on pop_valid and pop_ready; pop_valid = (count != 0); pop_idx/pop_val show the head entry combinationally from storage (show-ahead, zero-latency read).
REQ-025 Pops continue in HALT so the consumer can drain; pushes are refused.
REQ-026 Simultaneous push and pop with 0 < count < DEPTH: both occur, count unchanged.
REQ-027 Push into empty queue with pop_ready=1 the same cycle: no pop (pop_valid=0); count becomes 1.
REQ-028 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count reaches DEPTH exactly at full.
REQ-029 push_valid while count == DEPTH in RUN: entry dropped, overflow set, no other state change.
REQ-030 clear has priority over push and pop in the same cycle; the push and pop are both ignored.
REQ-031 conflict and overflow, once set, stay set until clear or reset; conflict_idx never updates while conflict=1.

Reset
REQ-032 When reset_n=0 at a rising edge: state=RUN, pointers=0, count=0, assigned=0, value=0, conflict=0, conflict_idx=0, overflow=0.
REQ-033 Reset mid-operation discards all queued entries; pop_valid=0 and push_ready=1 on the first cycle after reset_n returns to 1.
REQ-034 Storage array contents need no reset; pop_idx/pop_val are don't-care while pop_valid=0.

Configuration
REQ-035 Macro IMPL_FIFO_DUP_FILTER_EN defined: a firing push with assigned[push_idx]=1 and value[push_idx]=push_val is consumed (counts as accepted) but not written.
REQ-036 Macro undefined: duplicate same-polarity pushes are written as normal entries; conflict detection is unchanged.

Structure
REQ-037 Shared package bcp_pkg holds IDX_W default, DEPTH default, state encoding (RUN, HALT), and the entry type {idx, val}.
REQ-038 One sub-module, impl_fifo_mem: DEPTH x (IDX_W+1) storage, synchronous write, asynchronous read; all control logic stays in implication_fifo.

Verification
REQ-039 After reset, push (idx 5,val 1), (idx 2,val 0); pop with pop_ready=1 -> pops return (5,1) then (2,0); count 2->1->0.
REQ-040 Fill 8 distinct variables, no pop -> count=8, push_ready=0; one more push_valid -> overflow=1, count stays 8.
REQ-041 Push (3,1) then (3,0) -> conflict=1, conflict_idx=3, count=1, push_ready=0; pop still returns (3,1); clear -> conflict=0, state RUN.
REQ-042 Push (4,1) twice: with IMPL_FIFO_DUP_FILTER_EN -> count=1; without it -> count=2.
REQ-043 With count=3, assert push and pop together for 10 cycles -> count stays 3, pointers wrap, FIFO order preserved.
REQ-044 With count=5 and conflict=1, drive reset_n=0 for one cycle -> all outputs at reset values, next push (0,1) accepted.
